bus_rdcyc85: RTL

Bus read-cycle master for the 8085-style multiplexed AD bus. It runs T1/T2/TW/T3 machine cycles and drives the low address onto the shared AD lines through the team's tri-state buffer (`zbuffer`) via an output-enable. It then releases the lines and captures whatever the addressed device drives back. It sits between the core's bus control unit and the external AD/A-high pins, and is the reading end of the tri-stated AD bus.

---
 rtl/bus_rdcyc85.sv | 122 ++++++++++++
 1 files changed

// File: rtl/bus_rdcyc85.sv
// bus_rdcyc85: 8085-style multiplexed-AD read-cycle master (T1 / T2 / TW / T3).
// Optional macro BUSRD_TIMEOUT_EN bounds TW to WAITMAX cycles and flags err with done.
module bus_rdcyc85 #(
    parameter int ADDRSIZE = 16,
    parameter int DATASIZE = 8,
    parameter int WAITMAX  = 7
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [ADDRSIZE-1:0]          addr,
    input  logic                         ready,
    input  logic [DATASIZE-1:0]          ad_in,
    output logic [DATASIZE-1:0]          ad_out,
    output logic                         ad_oe,
    output logic [ADDRSIZE-DATASIZE-1:0] a_hi,
    output logic                         ale,
    output logic                         rd_n,
    output logic                         busy,
    output logic                         done,
    output logic [DATASIZE-1:0]          rdata,
    output logic                         err
);

    typedef enum logic [2:0] {IDLE, T1, T2, TW, T3} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDRSIZE-1:0] addr_q;
    logic                timeout_hit;

`ifdef BUSRD_TIMEOUT_EN
    localparam int CW = (WAITMAX < 1) ? 1 : $clog2(WAITMAX + 1);

    logic [CW-1:0] wait_cnt;
    logic          timed_out;
    logic          err_q;

    assign timeout_hit = (state == TW) && !ready && (wait_cnt == CW'(WAITMAX));

    // wait_cnt holds the number of the TW cycle currently in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt  <= '0;
            timed_out <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            err_q <= (state == T3) && timed_out;
            if (state == T1) begin
                wait_cnt  <= '0;
                timed_out <= 1'b0;
            end else begin
                if (state_nxt == TW)
                    wait_cnt <= wait_cnt + 1'b1;
                if (timeout_hit)
                    timed_out <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    localparam int unused_waitmax = WAITMAX;

    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            addr_q <= '0;
            rdata  <= '0;
            done   <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= (state == T3);
            if ((state == IDLE) && start)
                addr_q <= addr;
            if (state == T3)
                rdata <= ad_in;
        end
    end

    // AD is only driven in T1; the strobe owns T2..T3, so the two never overlap
    always_comb begin
        state_nxt = state;
        ale       = 1'b0;
        ad_oe     = 1'b0;
        rd_n      = 1'b1;
        case (state)
            IDLE: begin
                if (start)
                    state_nxt = T1;
            end
            T1: begin
                ale       = 1'b1;
                ad_oe     = 1'b1;
                state_nxt = T2;
            end
            T2: begin
                rd_n      = 1'b0;
                state_nxt = ready ? T3 : TW;
            end
            TW: begin
                rd_n = 1'b0;
                if (ready || timeout_hit)
                    state_nxt = T3;
            end
            T3: begin
                rd_n      = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ad_out = addr_q[DATASIZE-1:0];
    assign a_hi   = addr_q[ADDRSIZE-1:DATASIZE];
    assign busy   = (state != IDLE);

endmodule
